// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch-unit bus bundle: AR/R instruction-memory channel, execute redirect and decode output.
// The master modport is the fetch unit; the slave modport is the surrounding memory/pipeline.
interface ifu_fetch_ctrl_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        fetch_err;

   modport master (
      output araddr, arvalid, rready, out_valid, out_inst, out_pc, fetch_err,
      input  arready, rdata, rresp, rvalid, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  araddr, arvalid, rready, out_valid, out_inst, out_pc, fetch_err,
      output arready, rdata, rresp, rvalid, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch: one outstanding AR/R read per instruction, redirect-aware.
// Optional macro IFU_MISALIGN_CHECK_EN: a misaligned redirect target raises fetch_err and halts.
module ifu_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                clk,
   input  logic                rst,
   ifu_fetch_ctrl_if.master    bus
);

   typedef enum logic [1:0] {S_ADDR, S_DATA, S_HOLD, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] opc_q, opc_d;
   logic        err_q, err_d;
   logic        flush_q, flush_d;
   logic        redirect_bad;

`ifdef IFU_MISALIGN_CHECK_EN
   assign redirect_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
   assign redirect_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_ADDR;
         pc_q    <= RESET_PC;
         inst_q  <= 32'd0;
         opc_q   <= 32'd0;
         err_q   <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         opc_q   <= opc_d;
         err_q   <= err_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      opc_d   = opc_q;
      err_d   = err_q;
      flush_d = flush_q;
      case (state_q)
         S_ADDR: begin
            if (bus.redirect_valid) begin
               pc_d = bus.redirect_pc;
               // The old address was accepted this cycle: its data must be thrown away.
               if (bus.arready) begin
                  flush_d = 1'b1;
                  state_d = S_DATA;
               end
            end else if (bus.arready) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bus.redirect_valid) begin
               pc_d = bus.redirect_pc;
               if (bus.rvalid) begin
                  flush_d = 1'b0;
                  state_d = S_ADDR;
               end else begin
                  flush_d = 1'b1;
               end
            end else if (bus.rvalid) begin
               if (flush_q) begin
                  flush_d = 1'b0;
                  state_d = S_ADDR;
               end else if (bus.rresp != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  inst_d  = bus.rdata;
                  opc_d   = pc_q;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // A redirect beats a simultaneous decode handshake, so no sequential step.
            if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               state_d = S_ADDR;
            end else if (bus.out_ready) begin
               pc_d    = pc_q + PC_STEP;
               state_d = S_ADDR;
            end
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
      if (redirect_bad && (state_q != S_HALT)) begin
         err_d   = 1'b1;
         flush_d = 1'b0;
         state_d = S_HALT;
      end
   end

   always_comb begin
      bus.araddr    = pc_q;
      bus.arvalid   = 1'b0;
      bus.rready    = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_inst  = inst_q;
      bus.out_pc    = opc_q;
      bus.fetch_err = err_q;
      if (!rst) begin
         bus.arvalid   = (state_q == S_ADDR);
         bus.rready    = (state_q == S_DATA);
         bus.out_valid = (state_q == S_HOLD);
      end
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed walk through the fetch scenarios, then a randomized run against a
// program-order reference model with an address-keyed instruction memory.
module tb_ifu_fetch_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   deliveries = 0;

   ifu_fetch_ctrl_if bus ();

   ifu_fetch_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] outstanding[$];

      rst = 1'b1;
      bus.arready = 1'b0;
      bus.rdata = 32'd0;
      bus.rresp = 2'b00;
      bus.rvalid = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.out_ready = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_arvalid", bus.arvalid, 0);
      check("rst_rready", bus.rready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_fetch_err", bus.fetch_err, 0);
      check("rst_out_inst", bus.out_inst, 0);
      check("rst_out_pc", bus.out_pc, 0);
      check("rst_araddr", bus.araddr, 32'h8000_0000);

      // Streaming: one instruction every third cycle
      rst = 1'b0;
      bus.arready = 1'b1;
      bus.rvalid = 1'b1;
      bus.rdata = 32'h0000_0013;
      bus.out_ready = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("seq_arvalid", bus.arvalid, 1);
         check("seq_araddr", bus.araddr, 32'h8000_0000 + 32'(4 * i));
         tick();
         check("seq_rready", bus.rready, 1);
         tick();
         check("seq_out_valid", bus.out_valid, 1);
         check("seq_out_pc", bus.out_pc, 32'h8000_0000 + 32'(4 * i));
         check("seq_out_inst", bus.out_inst, 32'h0000_0013);
         $display("deliver pc=%h inst=%h", bus.out_pc, bus.out_inst);
         tick();
      end

      // Decode stall in HOLD
      bus.out_ready = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_out_valid", bus.out_valid, 1);
         check("stall_out_pc", bus.out_pc, 32'h8000_000C);
         check("stall_out_inst", bus.out_inst, 32'h0000_0013);
         check("stall_arvalid", bus.arvalid, 0);
         check("stall_araddr", bus.araddr, 32'h8000_000C);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("stall_next_araddr", bus.araddr, 32'h8000_0010);
      check("stall_next_arvalid", bus.arvalid, 1);

      // Redirect colliding with the decode handshake
      tick();
      tick();
      check("hs_redir_out_pc", bus.out_pc, 32'h8000_0010);
      check("hs_redir_out_valid", bus.out_valid, 1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8000_0200;
      tick();
      bus.redirect_valid = 1'b0;
      check("hs_redir_out_valid_drop", bus.out_valid, 0);
      check("hs_redir_arvalid", bus.arvalid, 1);
      check("hs_redir_araddr", bus.araddr, 32'h8000_0200);

      // Redirect while waiting on data; stale data must vanish
      bus.rvalid = 1'b0;
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8000_0100;
      tick();
      bus.redirect_valid = 1'b0;
      check("data_redir_rready", bus.rready, 1);
      check("data_redir_araddr", bus.araddr, 32'h8000_0100);
      tick();
      tick();
      bus.rvalid = 1'b1;
      bus.rdata = 32'hDEAD_BEEF;
      tick();
      check("flush_out_valid", bus.out_valid, 0);
      check("flush_arvalid", bus.arvalid, 1);
      check("flush_araddr", bus.araddr, 32'h8000_0100);
      bus.rdata = 32'h0000_0013;
      tick();
      tick();
      check("flush_next_out_valid", bus.out_valid, 1);
      check("flush_next_out_inst", bus.out_inst, 32'h0000_0013);
      check("flush_next_out_pc", bus.out_pc, 32'h8000_0100);
      tick();

      // Error response halts until reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         tick();
         tick();
         tick();
      end
      check("err_araddr", bus.araddr, 32'h8000_0008);
      tick();
      bus.rresp = 2'b10;
      tick();
      bus.rresp = 2'b00;
      check("err_fetch_err", bus.fetch_err, 1);
      check("err_out_valid", bus.out_valid, 0);
      check("err_arvalid", bus.arvalid, 0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8000_0300;
      tick();
      bus.redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("halt_fetch_err", bus.fetch_err, 1);
         check("halt_arvalid", bus.arvalid, 0);
         check("halt_out_valid", bus.out_valid, 0);
         check("halt_rready", bus.rready, 0);
         check("halt_araddr", bus.araddr, 32'h8000_0008);
         tick();
      end
      rst = 1'b1;
      tick();
      check("err_clear", bus.fetch_err, 0);
      rst = 1'b0;
      #1;
      check("err_restart_arvalid", bus.arvalid, 1);
      check("err_restart_araddr", bus.araddr, 32'h8000_0000);

      // Misaligned redirect target
      bus.arready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h8000_0102;
      tick();
      bus.redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
      check("misalign_fetch_err", bus.fetch_err, 1);
      check("misalign_arvalid", bus.arvalid, 0);
`else
      check("misalign_fetch_err", bus.fetch_err, 0);
      check("misalign_arvalid", bus.arvalid, 1);
      check("misalign_araddr", bus.araddr, 32'h8000_0102);
`endif

      // Randomized run against the program-order model
      rst = 1'b1;
      bus.rvalid = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      rst = 1'b0;
      exp_pc = 32'h8000_0000;
      outstanding.delete();
      for (int cyc = 0; cyc < 2500; cyc++) begin
         bus.arready = 1'($urandom_range(0, 1));
         bus.rvalid = (outstanding.size() > 0) && ($urandom_range(0, 2) != 0);
         bus.rdata = bus.rvalid ? mem_word(outstanding[0]) : $urandom();
         bus.rresp = 2'b00;
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.redirect_valid = ($urandom_range(0, 11) == 0);
         bus.redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                         : 32'h8000_0000 + (32'($urandom_range(0, 63)) << 2);
         #1;
         if (bus.arvalid && bus.arready) begin
            check("rand_araddr", bus.araddr, exp_pc);
            outstanding.push_back(bus.araddr);
         end
         if (bus.rvalid && bus.rready)
            void'(outstanding.pop_front());
         if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            check("rand_out_pc", bus.out_pc, exp_pc);
            check("rand_out_inst", bus.out_inst, mem_word(exp_pc));
            $display("deliver pc=%h inst=%h", bus.out_pc, bus.out_inst);
            exp_pc = exp_pc + 32'd4;
            deliveries++;
         end
         if (bus.redirect_valid)
            exp_pc = bus.redirect_pc;
         tick();
      end
      check("rand_progress", 32'(deliveries > 100), 1);
      check("rand_no_error", bus.fetch_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
